// File: rtl/port_periph_pkg.sv
// Shared defaults for the CPU data-port peripheral endpoint.
// Kept in one place so the CPU top and the bench agree on geometry.
package port_periph_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/port_periph_sync_fifo.sv
// Synchronous FIFO. A push into a full FIFO is accepted when a pop
// happens on the same edge. There is no bypass from an empty FIFO.
module port_periph_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/port_periph.sv
// Peripheral end of the CPU data PORT: CPU writes go to a TX FIFO and
// one external RX byte is held and driven onto PORT while the CPU is idle.
module port_periph
    import port_periph_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    inout  wire  [WIDTH-1:0] PORT,
    input  logic             PORT_WR,
    input  logic             PORT_RD,
    output logic [WIDTH-1:0] TX_DATA,
    output logic             TX_VALID,
    input  logic             TX_READY,
    input  logic [WIDTH-1:0] RX_DATA,
    input  logic             RX_VALID,
    output logic             RX_READY,
    output logic             RX_EMPTY,
    output logic             TX_FULL,
    output logic             OVF,
    input  logic             OVF_CLR
);
    logic [WIDTH-1:0] rx_hold;
    logic             tx_empty;
    logic             tx_pop;
    logic             tx_drop;
    logic             rx_accept;

    assign tx_pop    = TX_VALID & TX_READY;
    assign TX_VALID  = ~tx_empty;
    assign tx_drop   = PORT_WR & TX_FULL & ~tx_pop;
    assign RX_READY  = RX_EMPTY | PORT_RD;
    assign rx_accept = RX_VALID & RX_READY;

    // Direction follows the CPU's port-enable combinationally.
    assign PORT = PORT_WR ? {WIDTH{1'bz}} : rx_hold;

    port_periph_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (PORT_WR),
        .push_data (PORT),
        .pop       (tx_pop),
        .pop_data  (TX_DATA),
        .full      (TX_FULL),
        .empty     (tx_empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_hold  <= '0;
            RX_EMPTY <= 1'b1;
            OVF      <= 1'b0;
        end else begin
            // A read clears the flag but the byte stays on the bus.
            if (rx_accept) begin
                rx_hold  <= RX_DATA;
                RX_EMPTY <= 1'b0;
            end else if (PORT_RD) begin
                RX_EMPTY <= 1'b1;
            end
            if (OVF_CLR)      OVF <= 1'b0;
            else if (tx_drop) OVF <= 1'b1;
        end
    end
endmodule

// File: tb/tb_port_periph.sv
// Bench for port_periph: queue-based TX scoreboard plus a small RX/OVF model.
module tb_port_periph;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    wire  [WIDTH-1:0] PORT;
    logic             PORT_WR;
    logic             PORT_RD;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             RX_READY;
    logic             RX_EMPTY;
    logic             TX_FULL;
    logic             OVF;
    logic             OVF_CLR;
    logic [WIDTH-1:0] cpu_data;

    assign PORT = PORT_WR ? cpu_data : {WIDTH{1'bz}};

    port_periph #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PORT     (PORT),
        .PORT_WR  (PORT_WR),
        .PORT_RD  (PORT_RD),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .RX_EMPTY (RX_EMPTY),
        .TX_FULL  (TX_FULL),
        .OVF      (OVF),
        .OVF_CLR  (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] tx_q [$];
    logic [WIDTH-1:0] exp_hold;
    logic             exp_empty;
    logic             exp_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("tx_valid", {31'd0, TX_VALID}, {31'd0, tx_q.size() != 0});
        chk("tx_full", {31'd0, TX_FULL}, {31'd0, tx_q.size() == DEPTH});
        if (tx_q.size() != 0) chk("tx_head", {24'd0, TX_DATA}, {24'd0, tx_q[0]});
        chk("ovf", {31'd0, OVF}, {31'd0, exp_ovf});
        chk("rx_empty", {31'd0, RX_EMPTY}, {31'd0, exp_empty});
        chk("rx_ready", {31'd0, RX_READY}, {31'd0, exp_empty | PORT_RD});
        if (!PORT_WR) chk("port_rx", {24'd0, PORT}, {24'd0, exp_hold});
        else          chk("port_cpu", {24'd0, PORT}, {24'd0, cpu_data});
    endtask

    // One clock: score the TX handshake and advance the model at the
    // falling edge, then check registered outputs just after the rising edge.
    task automatic step();
        logic pop_now;
        logic full_m;
        @(negedge CLK);
        pop_now = TX_READY && (tx_q.size() != 0);
        full_m  = (tx_q.size() == DEPTH);
        if (TX_VALID && TX_READY) begin
            if (tx_q.size() == 0) chk("tx_spurious", 32'd1, 32'd0);
            else                  chk("tx_data", {24'd0, TX_DATA}, {24'd0, tx_q[0]});
        end else if (pop_now) begin
            chk("tx_valid_pop", {31'd0, TX_VALID}, 32'd1);
        end
        if (pop_now) void'(tx_q.pop_front());
        if (PORT_WR && (!full_m || pop_now)) tx_q.push_back(cpu_data);
        if (OVF_CLR) exp_ovf = 1'b0;
        else if (PORT_WR && full_m && !pop_now) exp_ovf = 1'b1;
        if (RX_VALID && (exp_empty || PORT_RD)) begin
            exp_hold  = RX_DATA;
            exp_empty = 1'b0;
        end else if (PORT_RD) begin
            exp_empty = 1'b1;
        end
        @(posedge CLK);
        #1;
        check_state();
    endtask

    task automatic model_reset();
        tx_q.delete();
        exp_hold  = '0;
        exp_empty = 1'b1;
        exp_ovf   = 1'b0;
    endtask

    task automatic idle();
        PORT_WR  = 1'b0;
        PORT_RD  = 1'b0;
        TX_READY = 1'b0;
        RX_VALID = 1'b0;
        OVF_CLR  = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] seq3 [3];
        seq3 = '{8'h11, 8'h22, 8'h33};
        idle();
        cpu_data = '0;
        RX_DATA  = '0;
        RST_N    = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check_state();
        chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);

        // Three writes with consumer stalled, then drain in order.
        PORT_WR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_data = seq3[i];
            step();
        end
        PORT_WR  = 1'b0;
        TX_READY = 1'b1;
        repeat (4) step();
        chk("tx_drained", {31'd0, TX_VALID}, 32'd0);

        // Fill, overflow drop, full-plus-pop acceptance, OVF clear.
        TX_READY = 1'b0;
        PORT_WR  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cpu_data = 8'hA0 + 8'(i);
            step();
        end
        chk("full_after_fill", {31'd0, TX_FULL}, 32'd1);
        cpu_data = 8'h55;
        step();
        chk("ovf_set", {31'd0, OVF}, 32'd1);
        cpu_data = 8'h66;
        TX_READY = 1'b1;
        step();
        chk("full_push_pop", {31'd0, TX_FULL}, 32'd1);
        PORT_WR  = 1'b0;
        TX_READY = 1'b0;
        OVF_CLR  = 1'b1;
        step();
        chk("ovf_clr", {31'd0, OVF}, 32'd0);
        OVF_CLR  = 1'b0;
        TX_READY = 1'b1;
        repeat (DEPTH + 1) step();

        // Sustained push+pop, one per cycle.
        PORT_WR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_data = 8'($urandom_range(0, 255));
            step();
        end
        PORT_WR = 1'b0;
        repeat (3) step();

        // RX accept, bus release under CPU drive, stall, read+accept.
        RX_VALID = 1'b1;
        RX_DATA  = 8'hA5;
        step();
        RX_VALID = 1'b0;
        chk("rx_a5", {24'd0, PORT}, 32'h0000_00A5);
        PORT_WR  = 1'b1;
        cpu_data = 8'hC3;
        #1;
        chk("port_release", {24'd0, PORT}, 32'h0000_00C3);
        step();
        PORT_WR = 1'b0;
        #1;
        chk("port_reappear", {24'd0, PORT}, 32'h0000_00A5);
        RX_VALID = 1'b1;
        RX_DATA  = 8'h5A;
        repeat (2) step();
        PORT_RD = 1'b1;
        step();
        chk("rx_5a", {24'd0, PORT}, 32'h0000_005A);
        RX_VALID = 1'b0;
        step();
        chk("rd_keeps_byte", {24'd0, PORT}, 32'h0000_005A);
        step();
        PORT_RD = 1'b0;

        // One RX byte per cycle with PORT_RD every cycle.
        RX_VALID = 1'b1;
        PORT_RD  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            RX_DATA = 8'h30 + 8'(i);
            step();
        end
        idle();
        step();

        // Asynchronous reset mid-stream.
        PORT_WR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_data = 8'hD0 + 8'(i);
            step();
        end
        PORT_WR  = 1'b0;
        RX_VALID = 1'b1;
        RX_DATA  = 8'h77;
        step();
        RX_VALID = 1'b0;
        #2;
        RST_N    = 1'b0;
        TX_READY = 1'b1;
        #1;
        model_reset();
        check_state();
        chk("rst_mid_tx_data", {24'd0, TX_DATA}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/port_periph.md
# port_periph

Peripheral-side endpoint of the CPU's bidirectional data PORT. Accepts bytes the CPU writes onto PORT, buffers them in a small TX FIFO and hands them to an external consumer over a valid/ready handshake. Takes bytes from an external producer over a valid/ready handshake, holds one, and drives it onto PORT whenever the CPU is not driving, so the register file's port register samples it.

## Interface
- WIDTH, 8, data width of PORT and both handshake buses
- DEPTH, 4, TX FIFO entries; power of two, ≥2
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- PORT  inout  WIDTH  shared data bus to the CPU register file
- PORT_WR  in  1  CPU is driving PORT this cycle (the CPU's port-enable)
- PORT_RD  in  1  CPU consumes the current RX byte (one-cycle pulse)
- TX_DATA  out  WIDTH  head of TX FIFO
- TX_VALID  out  1  TX FIFO non-empty
- TX_READY  in  1  external consumer accepts TX_DATA
- RX_DATA  in  WIDTH  byte from external producer
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  block can accept RX_DATA
- RX_EMPTY  out  1  no unread RX byte held
- TX_FULL  out  1  TX FIFO holds DEPTH entries
- OVF  out  1  sticky: a CPU write was dropped
- OVF_CLR  in  1  clears OVF

## Operation
- Bus drive: PORT = RX_HOLD when PORT_WR=0, else high-Z. Combinational on PORT_WR; no registered direction bit.
- TX push: on CLK edge with PORT_WR=1, PORT is written into FIFO if not full, or if full and a pop occurs the same edge.
- Push on full without pop: byte dropped, FIFO unchanged, OVF←1.
- TX pop: TX_VALID & TX_READY at edge advances read pointer. TX_DATA comes from storage at the read pointer; it is stable while TX_VALID=1 and not popped.
- Occupancy counter 0..DEPTH, width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- RX: RX_READY = RX_EMPTY | PORT_RD.
  - RX_VALID & RX_READY at edge: RX_HOLD←RX_DATA, RX_EMPTY←0.
  - PORT_RD without new accept: RX_EMPTY←1, RX_HOLD retained. The bus keeps showing the last byte.
  - PORT_RD while RX_EMPTY=1: ignored.
- OVF: OVF_CLR has priority over a same-cycle set.

## Timing
- Reset (async assert, sync-to-CLK release by the system) gives:
  - FIFO empty: TX_VALID=0, TX_FULL=0
  - TX_DATA=0 (storage cleared)
  - RX_HOLD=0, RX_EMPTY=1, RX_READY=1, OVF=0
  - PORT driven 0 when PORT_WR=0
- CPU write → TX_VALID: 1 cycle (visible after the capturing edge).
- External RX accept → byte on PORT: 1 cycle. The CPU register samples it on the following edge.
- Throughput: one push and one pop per cycle sustained. One RX byte per cycle when PORT_RD pulses every cycle.
- Empty FIFO with push: no same-cycle pop (no bypass); TX_VALID rises next cycle.
- Reset mid-transfer: FIFO contents and RX_HOLD discarded. No handshake completes on the reset edge.

## Structure
- No shared-package typedefs required. Pointer/count widths are derived locally with $clog2.
- Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, count, full/empty, push/pop with full+pop acceptance. It is reusable elsewhere in the CPU.
- Top level holds the RX holding register, RX_EMPTY flag, OVF flag and tri-state assign.

## Test plan
- Reset, PORT_WR=0 → PORT=0x00, RX_READY=1, RX_EMPTY=1, TX_VALID=0, OVF=0.
- PORT_WR=1 with 0x11,0x22,0x33 on consecutive cycles, TX_READY=0 → TX_VALID next cycle. Then TX_READY=1 → TX_DATA 0x11,0x22,0x33 in order, then TX_VALID=0.
- Fill 4 entries (TX_READY=0) → TX_FULL=1.
  - Write 0x55 → dropped, OVF=1.
  - Write 0x66 with TX_READY=1 same cycle → accepted, TX_FULL stays 1.
  - OVF_CLR → OVF=0.
- RX_VALID with 0xA5 → RX_EMPTY=0 next cycle, PORT=0xA5, RX_READY=0. Second RX_VALID 0x5A stalls until PORT_RD; PORT_RD+RX_VALID same cycle → PORT=0x5A, RX_EMPTY stays 0.
- PORT_WR=1 while RX_HOLD=0xA5 → block releases PORT (no contention, testbench value seen); PORT_WR=0 → 0xA5 reappears.
- Assert RST_N low mid-stream with 3 TX entries and RX held → all outputs immediately at reset values; no TX handshake after release.
